// File: rtl/mreq_arb.sv
`default_nettype none
// ============================================================================
// Module   : mreq_arb
// Brief    : N-input round-robin arbiter forwarding one MREQ request at a time.
// Revision : 1.0
// ============================================================================
module mreq_arb #(
    parameter  int N  = 4,
    localparam int GW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  i_valid,
    output logic [N-1:0]  o_ready,
    output logic          o_valid,
    input  logic          i_ready,
    output logic [GW-1:0] o_grant,
    output logic          o_busy
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [GW-1:0]   ptr_q,   ptr_d;
    logic [GW-1:0]   grant_q, grant_d;

    logic [N-1:0]    w_rot;
    logic [GW-1:0]   w_off;
    logic [GW:0]     w_sum;
    logic [GW-1:0]   w_pick;

    // Rotate requests so that bit 0 is the master at ptr; the first set bit is the winner.
    assign w_rot = N'({i_valid, i_valid} >> ptr_q);

    always_comb begin
        w_off = '0;
        for (int j = N - 1; j >= 0; j--) begin
            if (w_rot[j]) begin
                w_off = GW'(j);
            end
        end
    end

    assign w_sum  = {1'b0, ptr_q} + {1'b0, w_off};
    assign w_pick = (w_sum >= (GW+1)'(N)) ? GW'(w_sum - (GW+1)'(N)) : w_sum[GW-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            grant_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        case (state_q)
            ST_IDLE: begin
                if (|i_valid) begin
                    grant_d = w_pick;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (i_ready) begin
                    // Wrap at N so non-power-of-two configurations never reach index N.
                    ptr_d   = (grant_q == GW'(N - 1)) ? '0 : grant_q + 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        o_valid = (state_q == ST_BUSY) && !rst;
        o_busy  = o_valid;
        o_grant = rst ? '0 : grant_q;
        o_ready = '0;
        if (o_valid && i_ready) begin
            o_ready = N'(1) << grant_q;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mreq_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_mreq_arb
// Brief    : Randomized scoreboard bench for mreq_arb (N=4) plus an N=3 wrap case.
// Revision : 1.0
// ============================================================================
module tb_mreq_arb;

    localparam int N  = 4;
    localparam int GW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  i_valid;
    logic [N-1:0]  o_ready;
    logic          o_valid;
    logic          i_ready;
    logic [GW-1:0] o_grant;
    logic          o_busy;

    logic          rst3;
    logic [2:0]    v3;
    logic [2:0]    rdy3;
    logic          val3;
    logic          r3;
    logic [1:0]    gr3;
    logic          busy3;

    always #5 clk = ~clk;

    mreq_arb #(.N(N)) u_dut (
        .clk     (clk),
        .rst     (rst),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_grant (o_grant),
        .o_busy  (o_busy)
    );

    mreq_arb #(.N(3)) u_dut3 (
        .clk     (clk),
        .rst     (rst3),
        .i_valid (v3),
        .o_ready (rdy3),
        .o_valid (val3),
        .i_ready (r3),
        .o_grant (gr3),
        .o_busy  (busy3)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: pending-grant list, scan from ptr using modulo arithmetic.
    bit m_busy  = 1'b0;
    int m_ptr   = 0;
    int m_grant = 0;
    int exp_q[$];

    always @(negedge clk) begin
        bit found;
        check("o_valid", {31'd0, o_valid}, {31'd0, (m_busy && !rst)});
        check("o_busy",  {31'd0, o_busy},  {31'd0, (m_busy && !rst)});
        check("o_grant", {30'd0, o_grant}, rst ? 32'd0 : m_grant);
        if (rst) begin
            m_busy  = 1'b0;
            m_ptr   = 0;
            m_grant = 0;
            exp_q.delete();
        end else if (m_busy) begin
            if (i_ready) begin
                m_busy = 1'b0;
                m_ptr  = (m_grant + 1) % N;
            end
        end else if (i_valid != '0) begin
            found = 1'b0;
            for (int j = 0; j < N; j++) begin
                if (!found && i_valid[(m_ptr + j) % N]) begin
                    found   = 1'b1;
                    m_grant = (m_ptr + j) % N;
                end
            end
            m_busy = 1'b1;
            exp_q.push_back(m_grant);
        end
    end

    // Monitor: pops the expected grant on every forwarded handshake.
    always @(negedge clk) begin
        if (o_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_grant", 32'(exp_q.size()), 32'd1);
            end else begin
                check("grant_hold", {30'd0, o_grant}, exp_q[0]);
                if (i_ready) begin
                    check("o_ready_onehot", {28'd0, o_ready}, 32'd1 << exp_q[0]);
                    void'(exp_q.pop_front());
                end else begin
                    check("o_ready_wait", {28'd0, o_ready}, 32'd0);
                end
            end
        end else begin
            check("o_ready_novalid", {28'd0, o_ready}, 32'd0);
        end
    end

    logic [N-1:0] last_ready = '0;
    always @(negedge clk) last_ready = o_ready;

    // Masters drop their request the cycle after seeing o_ready unless marked sticky.
    task automatic run(input int cycles, input logic [N-1:0] new_mask, input int p_new,
                       input int p_ready, input logic [N-1:0] sticky);
        for (int c = 0; c < cycles; c++) begin
            @(posedge clk);
            #1;
            i_valid = i_valid & ~(last_ready & ~sticky);
            for (int k = 0; k < N; k++) begin
                if (new_mask[k] && ($urandom_range(99) < p_new)) i_valid[k] = 1'b1;
            end
            i_ready = ($urandom_range(99) < p_ready);
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst     = 1'b1;
        i_valid = '0;
        i_ready = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst     = 1'b1;
        i_valid = '0;
        i_ready = 1'b0;
        rst3    = 1'b1;
        v3      = '0;
        r3      = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Single request from master 2 with ready tied high.
        run(1, 4'b0100, 100, 100, 4'b0000);
        run(4, 4'b0000, 0, 100, 4'b0000);

        // All masters request once from ptr=0.
        do_reset();
        run(1, 4'b1111, 100, 100, 4'b0000);
        run(10, 4'b0000, 0, 100, 4'b0000);

        // Masters 0 and 3 hold valid continuously.
        do_reset();
        run(1, 4'b1001, 100, 100, 4'b1001);
        run(8, 4'b0000, 0, 100, 4'b1001);
        @(posedge clk);
        #1;
        i_valid = '0;
        run(3, 4'b0000, 0, 100, 4'b0000);

        // Backpressure with the granted master dropping valid mid-wait.
        do_reset();
        run(1, 4'b0010, 100, 0, 4'b0000);
        run(2, 4'b0000, 0, 0, 4'b0000);
        @(posedge clk);
        #1;
        i_valid[1] = 1'b0;
        run(2, 4'b0000, 0, 0, 4'b0000);
        run(2, 4'b0000, 0, 100, 4'b0000);

        // Reset while busy with grant 2; master 2 keeps requesting.
        do_reset();
        run(1, 4'b0100, 100, 0, 4'b0000);
        run(1, 4'b0000, 0, 0, 4'b0000);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        run(4, 4'b0000, 0, 100, 4'b0000);

        // Randomized traffic, including a reset in the middle.
        do_reset();
        run(600, 4'b1111, 20, 50, 4'b0000);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        run(400, 4'b1111, 30, 60, N'($urandom));
        @(posedge clk);
        #1;
        i_valid = '0;
        run(12, 4'b0000, 0, 100, 4'b0000);
        @(negedge clk);
        check("drain_empty", 32'(exp_q.size()), 32'd0);

        // N=3: completing master 2 wraps ptr to 0.
        @(posedge clk);
        #1;
        rst3 = 1'b0;
        v3   = 3'b100;
        r3   = 1'b1;
        @(negedge clk);
        check("n3_idle_valid", {31'd0, val3}, 32'd0);
        @(negedge clk);
        check("n3_valid",  {31'd0, val3}, 32'd1);
        check("n3_grant2", {30'd0, gr3},  32'd2);
        check("n3_ready2", {29'd0, rdy3}, 32'd4);
        @(posedge clk);
        #1;
        v3 = 3'b111;
        @(negedge clk);
        check("n3_gap_valid", {31'd0, val3}, 32'd0);
        @(negedge clk);
        check("n3_wrap_valid", {31'd0, val3}, 32'd1);
        check("n3_wrap_grant", {30'd0, gr3},  32'd0);
        check("n3_wrap_ready", {29'd0, rdy3}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
